// File: rtl/aftab_csr_seq_ctrl_pkg.sv
// Shared constants for the aftab interrupt CSR save/restore sequencer.
// Holds the FSM state encoding and the default counter geometry.
package aftab_csr_seq_ctrl_pkg;

  localparam int unsigned DefaultLen = 3;
  localparam logic [2:0]  DefaultLastIdx = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSaveInit = 3'd1,
    StSaveAct  = 3'd2,
    StRstInit  = 3'd3,
    StRstAct   = 3'd4,
    StDone     = 3'd5
  } state_e;

endpackage

// File: rtl/aftab_csr_seq_ctrl.sv
// Walks CSR slots 0..lastIdx on interrupt entry (save) and lastIdx..0 on mret (restore),
// steering an external up/down counter that supplies the current slot index.
module aftab_csr_seq_ctrl
  import aftab_csr_seq_ctrl_pkg::*;
#(
  parameter int unsigned   len     = DefaultLen,
  parameter logic [len-1:0] lastIdx = len'(DefaultLastIdx)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           interEntry,
  input  logic           mretReq,
  input  logic           csrAck,
  input  logic [len-1:0] cntValue,
  output logic           zeroCnt,
  output logic           ldCnt,
  output logic           upCnt,
  output logic           dnCnt,
  output logic [len-1:0] ldValue,
  output logic           csrWrEn,
  output logic           csrRdEn,
  output logic           busy,
  output logic           done
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    zeroCnt = 1'b0;
    ldCnt   = 1'b0;
    upCnt   = 1'b0;
    dnCnt   = 1'b0;
    ldValue = '0;
    csrWrEn = 1'b0;
    csrRdEn = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Entry has priority over mret when both arrive together.
        if (interEntry) begin
          state_d = StSaveInit;
        end else if (mretReq) begin
          state_d = StRstInit;
        end
      end
      StSaveInit: begin
        zeroCnt = 1'b1;
        state_d = StSaveAct;
      end
      StSaveAct: begin
        csrWrEn = 1'b1;
        if (csrAck) begin
          if (cntValue == lastIdx) begin
            state_d = StDone;
          end else begin
            upCnt = 1'b1;
          end
        end
      end
      StRstInit: begin
        ldCnt   = 1'b1;
        ldValue = lastIdx;
        state_d = StRstAct;
      end
      StRstAct: begin
        csrRdEn = 1'b1;
        if (csrAck) begin
          if (cntValue == '0) begin
            state_d = StDone;
          end else begin
            dnCnt = 1'b1;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_aftab_csr_seq_ctrl.sv
// Bench for aftab_csr_seq_ctrl: closes the slot-counter loop, runs directed vectors,
// corner sequences and randomized traffic against a slot-walk reference model.
module tb_aftab_csr_seq_ctrl;

  localparam int LAST = 4;

  // Model walk kinds
  localparam int MIdle = 0;
  localparam int MSave = 1;
  localparam int MRest = 2;
  localparam int MDone = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       interEntry, mretReq, csrAck;
  logic [2:0] cntValue;
  logic       zeroCnt, ldCnt, upCnt, dnCnt;
  logic [2:0] ldValue;
  logic       csrWrEn, csrRdEn, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: walk kind plus slot position (-1 = init cycle before first slot)
  int m_mode = MIdle;
  int m_pos = 0;

  always #5 clk = ~clk;

  aftab_csr_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .interEntry(interEntry),
    .mretReq   (mretReq),
    .csrAck    (csrAck),
    .cntValue  (cntValue),
    .zeroCnt   (zeroCnt),
    .ldCnt     (ldCnt),
    .upCnt     (upCnt),
    .dnCnt     (dnCnt),
    .ldValue   (ldValue),
    .csrWrEn   (csrWrEn),
    .csrRdEn   (csrRdEn),
    .busy      (busy),
    .done      (done)
  );

  // External CSR slot counter
  always_ff @(posedge clk) begin
    if (rst)          cntValue <= '0;
    else if (zeroCnt) cntValue <= '0;
    else if (ldCnt)   cntValue <= ldValue;
    else if (upCnt)   cntValue <= cntValue + 3'd1;
    else if (dnCnt)   cntValue <= cntValue - 3'd1;
  end

  // Flag order: {busy, done, zero, ld, up, dn, wr, rd}
  function automatic logic [7:0] model_flags(input int mode, input int pos, input logic ack);
    logic [7:0] f;
    f = 8'h00;
    case (mode)
      MSave: begin
        f[7] = 1'b1;
        if (pos < 0) f[5] = 1'b1;
        else begin
          f[1] = 1'b1;
          if (ack && pos != LAST) f[3] = 1'b1;
        end
      end
      MRest: begin
        f[7] = 1'b1;
        if (pos < 0) f[4] = 1'b1;
        else begin
          f[0] = 1'b1;
          if (ack && pos != 0) f[2] = 1'b1;
        end
      end
      MDone: f = 8'b1100_0000;
      default: f = 8'h00;
    endcase
    return f;
  endfunction

  task automatic model_advance(input logic i_inter, input logic i_mret, input logic i_ack,
                               input logic i_rst);
    if (i_rst) begin
      m_mode = MIdle;
      m_pos  = 0;
    end else begin
      case (m_mode)
        MIdle: begin
          if (i_inter)     begin m_mode = MSave; m_pos = -1; end
          else if (i_mret) begin m_mode = MRest; m_pos = -1; end
        end
        MSave: begin
          if (m_pos < 0) m_pos = 0;
          else if (i_ack) begin
            if (m_pos == LAST) m_mode = MDone;
            else m_pos = m_pos + 1;
          end
        end
        MRest: begin
          if (m_pos < 0) m_pos = LAST;
          else if (i_ack) begin
            if (m_pos == 0) m_mode = MDone;
            else m_pos = m_pos - 1;
          end
        end
        default: m_mode = MIdle;
      endcase
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model across the posedge.
  task automatic step(input logic i_inter, input logic i_mret, input logic i_ack,
                      input logic i_rst, input logic use_tbl, input logic [7:0] t_flags,
                      input logic [2:0] t_ld, input logic t_chk, input logic [2:0] t_cnt,
                      input string name);
    logic [7:0] got, exp_f;
    logic [2:0] exp_ld;
    logic       chk_cnt;
    logic [2:0] exp_cnt;
    interEntry = i_inter;
    mretReq    = i_mret;
    csrAck     = i_ack;
    rst        = i_rst;
    @(negedge clk);
    got = {busy, done, zeroCnt, ldCnt, upCnt, dnCnt, csrWrEn, csrRdEn};
    if (use_tbl) begin
      exp_f   = t_flags;
      exp_ld  = t_ld;
      chk_cnt = t_chk;
      exp_cnt = t_cnt;
    end else begin
      exp_f   = model_flags(m_mode, m_pos, i_ack);
      exp_ld  = (m_mode == MRest && m_pos < 0) ? 3'(LAST) : 3'd0;
      chk_cnt = (m_mode == MSave || m_mode == MRest) && m_pos >= 0;
      exp_cnt = 3'(m_pos);
    end
    checks++;
    if (got !== exp_f) begin
      failures++;
      $display("FAIL %s flags cyc=%0d got=%b exp=%b", name, cyc, got, exp_f);
    end
    checks++;
    if (ldValue !== exp_ld) begin
      failures++;
      $display("FAIL %s ldValue cyc=%0d got=%0d exp=%0d", name, cyc, ldValue, exp_ld);
    end
    if (chk_cnt) begin
      checks++;
      if (cntValue !== exp_cnt) begin
        failures++;
        $display("FAIL %s slot cyc=%0d got=%0d exp=%0d", name, cyc, cntValue, exp_cnt);
      end
    end
    checks++;
    if ($countones({zeroCnt, ldCnt, upCnt, dnCnt}) > 1 || (csrWrEn && csrRdEn)) begin
      failures++;
      $display("FAIL %s exclusivity cyc=%0d cmds=%b wr=%b rd=%b", name, cyc,
               {zeroCnt, ldCnt, upCnt, dnCnt}, csrWrEn, csrRdEn);
    end
    model_advance(i_inter, i_mret, i_ack, i_rst);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mstep(input logic i_inter, input logic i_mret, input logic i_ack,
                       input logic i_rst, input string name);
    step(i_inter, i_mret, i_ack, i_rst, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, name);
  endtask

  typedef struct {
    logic       inter;
    logic       mret;
    logic       ack;
    logic [7:0] flags;
    logic [2:0] ld;
    logic       chk;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // Directed save then restore walk, csrAck high throughout.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'b0000_0000, 3'd0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'b1010_0000, 3'd0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'b1000_1010, 3'd0, 1'b1, 3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'b1000_1010, 3'd0, 1'b1, 3'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'b1000_1010, 3'd0, 1'b1, 3'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'b1000_1010, 3'd0, 1'b1, 3'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'b1000_0010, 3'd0, 1'b1, 3'd4};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'b1100_0000, 3'd0, 1'b0, 3'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'b0000_0000, 3'd0, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'b1001_0000, 3'd4, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'b1000_0101, 3'd0, 1'b1, 3'd4};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'b1000_0101, 3'd0, 1'b1, 3'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'b1000_0101, 3'd0, 1'b1, 3'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'b1000_0101, 3'd0, 1'b1, 3'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'b1000_0001, 3'd0, 1'b1, 3'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 8'b1100_0000, 3'd0, 1'b0, 3'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000, 3'd0, 1'b0, 3'd0};

    interEntry = 1'b0;
    mretReq    = 1'b0;
    csrAck     = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].inter, vecs[i].mret, vecs[i].ack, 1'b0, 1'b1, vecs[i].flags, vecs[i].ld,
           vecs[i].chk, vecs[i].cnt, "vec");
    end

    // Ack stall at slot 2: slot must hold and resume without skipping.
    mstep(1'b1, 1'b0, 1'b0, 1'b0, "stall");
    mstep(1'b0, 1'b0, 1'b1, 1'b0, "stall");
    mstep(1'b0, 1'b0, 1'b1, 1'b0, "stall");
    mstep(1'b0, 1'b0, 1'b1, 1'b0, "stall");
    for (int i = 0; i < 3; i++) mstep(1'b0, 1'b0, 1'b0, 1'b0, "stall_hold");
    for (int i = 0; i < 5; i++) mstep(1'b0, 1'b0, 1'b1, 1'b0, "stall_resume");
    mstep(1'b0, 1'b0, 1'b0, 1'b0, "stall_idle");

    // Simultaneous requests pick save; mret mid-walk ignored.
    mstep(1'b1, 1'b1, 1'b1, 1'b0, "both");
    mstep(1'b0, 1'b1, 1'b1, 1'b0, "both");
    for (int i = 0; i < 6; i++) mstep(1'b0, 1'b1, 1'b1, 1'b0, "both_mret_ignored");
    mstep(1'b0, 1'b0, 1'b1, 1'b0, "both_idle");

    // Reset in SAVE_ACT at slot 3, then clean restart.
    mstep(1'b1, 1'b0, 1'b1, 1'b0, "rst_mid");
    for (int i = 0; i < 4; i++) mstep(1'b0, 1'b0, 1'b1, 1'b0, "rst_mid");
    mstep(1'b0, 1'b0, 1'b1, 1'b1, "rst_mid_assert");
    mstep(1'b0, 1'b0, 1'b1, 1'b0, "rst_mid_idle");
    mstep(1'b1, 1'b0, 1'b1, 1'b0, "rst_restart");
    for (int i = 0; i < 7; i++) mstep(1'b0, 1'b0, 1'b1, 1'b0, "rst_restart");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      mstep(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 59) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aftab_csr_seq_ctrl.md
AFTAB_CSR_SEQ_CTRL -- requirements
Module: aftab_csr_seq_ctrl

Interface
REQ-001 Parameter len, default 3: width of the CSR counter value and load value.
REQ-002 Parameter lastIdx, default 3'd4: highest CSR slot index walked; SHALL satisfy 0 < lastIdx <= 2^len-1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 interEntry  input  1  request to start the save walk (interrupt entry).
REQ-006 mretReq  input  1  request to start the restore walk (mret).
REQ-007 csrAck  input  1  CSR file has completed the access for the current slot.
REQ-008 cntValue  input  len  current counter value, the slot index.
REQ-009 zeroCnt / ldCnt / upCnt / dnCnt  output  1 each  counter commands.
REQ-010 ldValue  output  len  counter load value.
REQ-011 csrWrEn  output  1  write slot cntValue (save walk).
REQ-012 csrRdEn  output  1  read slot cntValue (restore walk).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a walk completes.

Function
REQ-015 The FSM SHALL have states IDLE, SAVE_INIT, SAVE_ACT, RST_INIT, RST_ACT, DONE.
REQ-016 IDLE: interEntry=1 -> SAVE_INIT; else mretReq=1 -> RST_INIT; else stay. If both requests are high, interEntry wins.
REQ-017 SAVE_INIT: zeroCnt=1 for exactly one cycle -> SAVE_ACT.
REQ-018 SAVE_ACT: csrWrEn=1. On csrAck=1 with cntValue==lastIdx -> DONE, no counter command; on csrAck=1 otherwise -> upCnt=1 in the same cycle and stay; on csrAck=0 -> hold with no command.
REQ-019 RST_INIT: ldCnt=1, ldValue=lastIdx for exactly one cycle -> RST_ACT.
REQ-020 RST_ACT: csrRdEn=1. On csrAck=1 with cntValue==0 -> DONE; on csrAck=1 otherwise -> dnCnt=1 and stay; on csrAck=0 -> hold.
REQ-021 DONE: done=1 for one cycle -> IDLE unconditionally.
REQ-022 At most one of zeroCnt, ldCnt, upCnt and dnCnt SHALL be high in any cycle; ldValue SHALL be 0 whenever ldCnt=0.
REQ-023 csrWrEn and csrRdEn SHALL never be high together and SHALL be 0 outside SAVE_ACT and RST_ACT respectively.
REQ-024 The counter updates on the edge after a command, so cntValue is valid in the cycle after each command. csrAck SHALL be sampled only in the ACT states and ignored elsewhere.
REQ-025 interEntry and mretReq SHALL be ignored while busy=1; no request queuing.
REQ-026 A walk of N=lastIdx+1 slots with csrAck tied high SHALL take 1 + N + 1 cycles from leaving IDLE to returning to IDLE.
REQ-027 Counter commands and CSR enables SHALL be combinational decodes of state, csrAck and cntValue; state is the only register.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE regardless of the current state, including mid-walk; the walk is abandoned with no done pulse.
REQ-029 While in IDLE (including after reset), all outputs SHALL be 0: busy=0, done=0, all commands 0, ldValue=0, csrWrEn=0, csrRdEn=0.
REQ-030 The counter is reset by the same rst; this block SHALL NOT issue zeroCnt during reset.

Structure
REQ-031 State encodings and the default lastIdx SHALL be defined as constants in the shared aftab interrupt package.
REQ-032 No sub-module. The block drives the external CSR counter; the bench SHALL instantiate that counter to close the cntValue loop.

Verification
REQ-033 Save walk, csrAck=1 throughout, lastIdx=4 -> zeroCnt at cycle 1; csrWrEn for slots 0..4 on cycles 2..6; upCnt on cycles 2..5; done on cycle 7.
REQ-034 Restore walk, csrAck=1 throughout -> ldCnt with ldValue=4; csrRdEn for slots 4,3,2,1,0; dnCnt four times; single done pulse.
REQ-035 Save walk with csrAck low for 3 cycles at slot 2 -> cntValue holds at 2 and csrWrEn stays high; stepping resumes on ack with no skipped slot.
REQ-036 interEntry=1 and mretReq=1 in the same IDLE cycle -> save walk taken; a second mretReq mid-walk is ignored.
REQ-037 rst asserted in SAVE_ACT at slot 3 -> next cycle IDLE with all outputs 0, no done pulse; a subsequent interEntry starts cleanly at slot 0.
REQ-038 All scenarios: assertion that at most one counter command is high per cycle and that csrWrEn and csrRdEn are never high together.
